// File: rtl/spu_regfile_wb.sv
// 128 x 128-bit SPU register file with three writeback ports and six registered read ports.
// Same-edge writes are forwarded to the read outputs. Same-address writes resolve youngest-first.
module spu_regfile_wb #(
    parameter int NUM_REGS = 128,
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 7,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rt_wb,
    input  logic [ADDR_W-1:0] rt_addr_wb,
    input  logic              reg_write_wb,
    input  logic [DATA_W-1:0] rt_int,
    input  logic [ADDR_W-1:0] rt_addr_int,
    input  logic              reg_write_int,
    input  logic [DATA_W-1:0] rt_odd,
    input  logic [ADDR_W-1:0] rt_addr_odd,
    input  logic              reg_write_odd,
    input  logic [ADDR_W-1:0] ra_even_addr,
    input  logic [ADDR_W-1:0] rb_even_addr,
    input  logic [ADDR_W-1:0] rc_even_addr,
    input  logic [ADDR_W-1:0] ra_odd_addr,
    input  logic [ADDR_W-1:0] rb_odd_addr,
    input  logic [ADDR_W-1:0] rc_odd_addr,
    output logic [DATA_W-1:0] ra_even,
    output logic [DATA_W-1:0] rb_even,
    output logic [DATA_W-1:0] rc_even,
    output logic [DATA_W-1:0] ra_odd,
    output logic [DATA_W-1:0] rb_odd,
    output logic [DATA_W-1:0] rc_odd,
    output logic [CNT_W-1:0]  wr_collision_cnt
);

    logic [DATA_W-1:0]     mem [NUM_REGS];
    logic [2**ADDR_W-1:0]  valid_map;
    logic                  collide;

    // Constant per-address map: only addresses below NUM_REGS are backed by storage.
    for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_map
        assign valid_map[i] = (i < NUM_REGS);
    end

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return valid_map[a];
    endfunction

    // Stored value after this edge's writes, with youngest-wins priority applied last.
    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (in_range(a)) begin
            v = mem[a];
            if (reg_write_int && rt_addr_int == a) v = rt_int;
            if (reg_write_wb  && rt_addr_wb  == a) v = rt_wb;
            if (reg_write_odd && rt_addr_odd == a) v = rt_odd;
        end
        return v;
    endfunction

    always_comb begin
        collide = 1'b0;
        if (reg_write_wb  && reg_write_int && rt_addr_wb  == rt_addr_int) collide = 1'b1;
        if (reg_write_wb  && reg_write_odd && rt_addr_wb  == rt_addr_odd) collide = 1'b1;
        if (reg_write_int && reg_write_odd && rt_addr_int == rt_addr_odd) collide = 1'b1;
    end

    // Later non-blocking assignments override earlier ones: int < wb < odd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else begin
            if (reg_write_int && in_range(rt_addr_int)) mem[rt_addr_int] <= rt_int;
            if (reg_write_wb  && in_range(rt_addr_wb))  mem[rt_addr_wb]  <= rt_wb;
            if (reg_write_odd && in_range(rt_addr_odd)) mem[rt_addr_odd] <= rt_odd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra_even <= '0;
            rb_even <= '0;
            rc_even <= '0;
            ra_odd  <= '0;
            rb_odd  <= '0;
            rc_odd  <= '0;
        end else begin
            ra_even <= read_value(ra_even_addr);
            rb_even <= read_value(rb_even_addr);
            rc_even <= read_value(rc_even_addr);
            ra_odd  <= read_value(ra_odd_addr);
            rb_odd  <= read_value(rb_odd_addr);
            rc_odd  <= read_value(rc_odd_addr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_collision_cnt <= '0;
        end else if (collide && wr_collision_cnt != '1) begin
            wr_collision_cnt <= wr_collision_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_spu_regfile_wb.sv
// Directed plus randomized checks of spu_regfile_wb against an array-based reference model.
module tb_spu_regfile_wb;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] rt_wb, rt_int, rt_odd;
    logic [6:0]   rt_addr_wb, rt_addr_int, rt_addr_odd;
    logic         reg_write_wb, reg_write_int, reg_write_odd;
    logic [6:0]   ra_even_addr, rb_even_addr, rc_even_addr;
    logic [6:0]   ra_odd_addr, rb_odd_addr, rc_odd_addr;
    logic [127:0] ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd;
    logic [15:0]  wr_collision_cnt;

    logic [127:0] model [128];
    int unsigned  mcnt;
    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [127:0] exp_rd [6];

    spu_regfile_wb #(.NUM_REGS(128), .DATA_W(128), .ADDR_W(7), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
        .rt_int(rt_int), .rt_addr_int(rt_addr_int), .reg_write_int(reg_write_int),
        .rt_odd(rt_odd), .rt_addr_odd(rt_addr_odd), .reg_write_odd(reg_write_odd),
        .ra_even_addr(ra_even_addr), .rb_even_addr(rb_even_addr), .rc_even_addr(rc_even_addr),
        .ra_odd_addr(ra_odd_addr), .rb_odd_addr(rb_odd_addr), .rc_odd_addr(rc_odd_addr),
        .ra_even(ra_even), .rb_even(rb_even), .rc_even(rc_even),
        .ra_odd(ra_odd), .rb_odd(rb_odd), .rc_odd(rc_odd),
        .wr_collision_cnt(wr_collision_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Youngest enabled writer to address a wins; otherwise the stored value.
    function automatic logic [127:0] winner(input logic [6:0] a);
        if (reg_write_odd && rt_addr_odd == a) return rt_odd;
        if (reg_write_wb  && rt_addr_wb  == a) return rt_wb;
        if (reg_write_int && rt_addr_int == a) return rt_int;
        return model[a];
    endfunction

    function automatic int unsigned pair_hits();
        int unsigned n;
        n = 0;
        if (reg_write_wb  && reg_write_int && rt_addr_wb  == rt_addr_int) n++;
        if (reg_write_wb  && reg_write_odd && rt_addr_wb  == rt_addr_odd) n++;
        if (reg_write_int && reg_write_odd && rt_addr_int == rt_addr_odd) n++;
        return n;
    endfunction

    task automatic idle();
        reg_write_wb = 1'b0; reg_write_int = 1'b0; reg_write_odd = 1'b0;
        rt_wb = '0; rt_int = '0; rt_odd = '0;
        rt_addr_wb = '0; rt_addr_int = '0; rt_addr_odd = '0;
        ra_even_addr = '0; rb_even_addr = '0; rc_even_addr = '0;
        ra_odd_addr = '0; rb_odd_addr = '0; rc_odd_addr = '0;
    endtask

    // One clock with current inputs; model advances and all outputs are checked 1 ns after the edge.
    task automatic step();
        logic [127:0] w_wb, w_int, w_odd;
        exp_rd[0] = winner(ra_even_addr);
        exp_rd[1] = winner(rb_even_addr);
        exp_rd[2] = winner(rc_even_addr);
        exp_rd[3] = winner(ra_odd_addr);
        exp_rd[4] = winner(rb_odd_addr);
        exp_rd[5] = winner(rc_odd_addr);
        w_wb = winner(rt_addr_wb); w_int = winner(rt_addr_int); w_odd = winner(rt_addr_odd);
        if (pair_hits() > 0 && mcnt < 65535) mcnt++;
        if (reg_write_wb)  model[rt_addr_wb]  = w_wb;
        if (reg_write_int) model[rt_addr_int] = w_int;
        if (reg_write_odd) model[rt_addr_odd] = w_odd;
        @(posedge clk);
        #1;
        check("ra_even", ra_even, exp_rd[0]);
        check("rb_even", rb_even, exp_rd[1]);
        check("rc_even", rc_even, exp_rd[2]);
        check("ra_odd",  ra_odd,  exp_rd[3]);
        check("rb_odd",  rb_odd,  exp_rd[4]);
        check("rc_odd",  rc_odd,  exp_rd[5]);
        check("coll_cnt", 128'(wr_collision_cnt), 128'(mcnt));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) model[i] = '0;
        mcnt = 0;
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b0;
        #12;
        check("reset_ra_even", ra_even, '0);
        check("reset_cnt", 128'(wr_collision_cnt), '0);
        @(negedge clk);
        reset = 1'b1;

        // 1) every address reads zero after reset
        for (int a = 0; a < 128; a += 6) begin
            ra_even_addr = 7'(a);     rb_even_addr = 7'((a + 1) % 128);
            rc_even_addr = 7'((a + 2) % 128); ra_odd_addr = 7'((a + 3) % 128);
            rb_odd_addr = 7'((a + 4) % 128);  rc_odd_addr = 7'((a + 5) % 128);
            step();
            check("t1_zero", ra_even | rb_even | rc_even | ra_odd | rb_odd | rc_odd, '0);
        end

        // 2) write then read next cycle
        idle();
        reg_write_wb = 1'b1; rt_addr_wb = 7'd5; rt_wb = {16{8'hA5}};
        step();
        idle();
        ra_even_addr = 7'd5;
        step();
        check("t2_ra_even", ra_even, {16{8'hA5}});

        // 3) three-way collision, odd wins, counter bumps once
        idle();
        reg_write_wb = 1'b1;  rt_addr_wb = 7'd9;  rt_wb = 128'd1;
        reg_write_int = 1'b1; rt_addr_int = 7'd9; rt_int = 128'd2;
        reg_write_odd = 1'b1; rt_addr_odd = 7'd9; rt_odd = 128'd3;
        rb_odd_addr = 7'd9;
        step();
        check("t3_rb_odd", rb_odd, 128'd3);
        check("t3_cnt", 128'(wr_collision_cnt), 128'd1);
        idle();
        ra_even_addr = 7'd9;
        step();
        check("t3_r9_holds", ra_even, 128'd3);

        // 4) write-first bypass, preceded by an older value
        idle();
        reg_write_int = 1'b1; rt_addr_int = 7'd12; rt_int = 128'd55;
        step();
        rt_int = 128'd7; rc_even_addr = 7'd12;
        step();
        check("t4_bypass", rc_even, 128'd7);

        // random traffic on a narrow address window to provoke collisions and bypass
        for (int n = 0; n < 400; n++) begin
            reg_write_wb = 1'($urandom); reg_write_int = 1'($urandom); reg_write_odd = 1'($urandom);
            rt_addr_wb = 7'($urandom_range(0, 15)); rt_addr_int = 7'($urandom_range(0, 15));
            rt_addr_odd = 7'($urandom_range(0, 15));
            rt_wb = {$urandom, $urandom, $urandom, $urandom};
            rt_int = {$urandom, $urandom, $urandom, $urandom};
            rt_odd = {$urandom, $urandom, $urandom, $urandom};
            ra_even_addr = 7'($urandom_range(0, 15)); rb_even_addr = 7'($urandom_range(0, 15));
            rc_even_addr = 7'($urandom_range(0, 127)); ra_odd_addr = 7'($urandom_range(0, 15));
            rb_odd_addr = 7'($urandom_range(0, 15)); rc_odd_addr = ra_even_addr;
            step();
            check("dup_read", rc_odd, ra_even);
        end

        // 6) asynchronous reset mid-cycle with a write pending
        idle();
        reg_write_odd = 1'b1; rt_addr_odd = 7'd20; rt_odd = 128'hDEAD_BEEF;
        ra_even_addr = 7'd3;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_ra_even_async", ra_even, '0);
        check("t6_rb_odd_async", rb_odd, '0);
        check("t6_cnt_async", 128'(wr_collision_cnt), '0);
        model_reset();
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        reset = 1'b1;
        ra_even_addr = 7'd20; rb_even_addr = 7'd9;
        step();
        check("t6_lost_write", ra_even, '0);

        // 5) saturate the collision counter
        idle();
        reg_write_wb = 1'b1; reg_write_odd = 1'b1;
        rt_addr_wb = 7'd40; rt_addr_odd = 7'd40; rt_wb = 128'd4; rt_odd = 128'd6;
        repeat (65534) @(posedge clk);
        #1;
        check("t5_cnt_fffe", 128'(wr_collision_cnt), 128'hFFFE);
        mcnt = 65534;
        model[40] = 128'd6;
        step();
        check("t5_cnt_ffff", 128'(wr_collision_cnt), 128'hFFFF);
        reg_write_int = 1'b1; rt_addr_int = 7'd40; rt_int = 128'd8;
        repeat (3) step();
        check("t5_cnt_sticks", 128'(wr_collision_cnt), 128'hFFFF);
        idle();
        ra_odd_addr = 7'd40;
        step();
        check("t5_r40", ra_odd, 128'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
